// File: rtl/wb_dual_port_bram_pkg.sv
// Shared definitions for the dual-port Wishbone block RAM: port indices and
// helpers deriving the byte-lane count and ack latency from the parameters.
package wb_dual_port_bram_pkg;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    // Number of byte lanes for a data width that is a multiple of 8.
    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

    // Cycles from accept to ack: one for the RAM read, plus the optional output stage.
    function automatic int ack_latency(input int read_pipe);
        return 1 + read_pipe;
    endfunction

endpackage

// File: rtl/wb_dpbram_port.sv
// One Wishbone pipelined port of the dual-port RAM: accept qualification,
// ack/data pipeline and squashing of pending acks when cyc is dropped.
module wb_dpbram_port
    import wb_dual_port_bram_pkg::*;
#(
    parameter int DW        = 32,
    parameter int READ_PIPE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cyc,
    input  logic          stb,
    input  logic          we,
    input  logic          collide_stall,
    input  logic [DW-1:0] rd_data,
    output logic          stall,
    output logic          accept,
    output logic          rd_accept,
    output logic          ack,
    output logic [DW-1:0] data
);

    logic s1_v;

    // Collision arbitration is the only source of backpressure; nothing is
    // stalled or accepted while reset is held.
    assign stall     = collide_stall & ~reset;
    assign accept    = cyc & stb & ~stall & ~reset;
    assign rd_accept = accept & ~we;

    // First pipeline stage: a request was accepted on the previous edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0;
        end else begin
            s1_v <= accept;
        end
    end

    generate
        if (ack_latency(READ_PIPE) == 1) begin : g_direct
            // RAM read register in the top already holds the last read word.
            assign ack  = s1_v & cyc;
            assign data = rd_data;
        end else begin : g_piped
            logic          s1_rd;
            logic          s2_v;
            logic [DW-1:0] data_q;

            // Extra output stage; a stage entry is dropped if cyc fell meanwhile.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_rd  <= 1'b0;
                    s2_v   <= 1'b0;
                    data_q <= '0;
                end else begin
                    s1_rd <= rd_accept;
                    s2_v  <= s1_v & cyc;
                    if (s1_v && s1_rd && cyc) begin
                        data_q <= rd_data;
                    end
                end
            end

            assign ack  = s2_v & cyc;
            assign data = data_q;
        end
    endgenerate

endmodule

// File: rtl/wb_dual_port_bram.sv
// Parametrised two-port Wishbone B4 pipelined block RAM with byte-lane writes,
// optional output register and same-address write collision arbitration.
// mutsel flips the collision priority; it is tied low in normal use and only
// driven by equivalence miters.
module wb_dual_port_bram
    import wb_dual_port_bram_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int READ_PIPE = 0,
    parameter int PRIO_A    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_a_cyc,
    input  logic                 i_a_stb,
    input  logic                 i_a_we,
    input  logic [AW-1:0]        i_a_addr,
    input  logic [DW-1:0]        i_a_data,
    input  logic [DW/8-1:0]      i_a_sel,
    output logic                 o_a_stall,
    output logic                 o_a_ack,
    output logic [DW-1:0]        o_a_data,
    input  logic                 i_b_cyc,
    input  logic                 i_b_stb,
    input  logic                 i_b_we,
    input  logic [AW-1:0]        i_b_addr,
    input  logic [DW-1:0]        i_b_data,
    input  logic [DW/8-1:0]      i_b_sel,
    output logic                 o_b_stall,
    output logic                 o_b_ack,
    output logic [DW-1:0]        o_b_data,
    input  logic                 mutsel
);

    localparam int SELW = sel_width(DW);

    logic [DW-1:0] mem [0:(2**AW)-1];

    logic          wr_req   [2];
    logic          coll_stl [2];
    logic          stall    [2];
    logic          accept   [2];
    logic          rd_acc   [2];
    logic [DW-1:0] rd_q     [2];
    logic          collide;
    logic          prio_a_eff;
    logic          winner_a;
    logic          stalled_a_q;
    logic          stalled_b_q;

    assign wr_req[PORT_A] = i_a_cyc & i_a_stb & i_a_we;
    assign wr_req[PORT_B] = i_b_cyc & i_b_stb & i_b_we;
    assign collide        = wr_req[PORT_A] & wr_req[PORT_B] & (i_a_addr == i_b_addr);
    assign prio_a_eff     = (PRIO_A != 0) ^ mutsel;

    // Pick the collision winner; a port stalled last cycle wins now so the
    // loser is only ever held off for a single cycle.
    always_comb begin
        winner_a = prio_a_eff;
        if (stalled_b_q) begin
            winner_a = 1'b0;
        end else if (stalled_a_q) begin
            winner_a = 1'b1;
        end
        coll_stl[PORT_A] = collide & ~winner_a;
        coll_stl[PORT_B] = collide & winner_a;
    end

    // Remember which port lost arbitration in the previous cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stalled_a_q <= 1'b0;
            stalled_b_q <= 1'b0;
        end else begin
            stalled_a_q <= stall[PORT_A];
            stalled_b_q <= stall[PORT_B];
        end
    end

    wb_dpbram_port #(.DW(DW), .READ_PIPE(READ_PIPE)) u_port_a (
        .clk           (i_clk),
        .reset         (i_reset),
        .cyc           (i_a_cyc),
        .stb           (i_a_stb),
        .we            (i_a_we),
        .collide_stall (coll_stl[PORT_A]),
        .rd_data       (rd_q[PORT_A]),
        .stall         (stall[PORT_A]),
        .accept        (accept[PORT_A]),
        .rd_accept     (rd_acc[PORT_A]),
        .ack           (o_a_ack),
        .data          (o_a_data)
    );

    wb_dpbram_port #(.DW(DW), .READ_PIPE(READ_PIPE)) u_port_b (
        .clk           (i_clk),
        .reset         (i_reset),
        .cyc           (i_b_cyc),
        .stb           (i_b_stb),
        .we            (i_b_we),
        .collide_stall (coll_stl[PORT_B]),
        .rd_data       (rd_q[PORT_B]),
        .stall         (stall[PORT_B]),
        .accept        (accept[PORT_B]),
        .rd_accept     (rd_acc[PORT_B]),
        .ack           (o_b_ack),
        .data          (o_b_data)
    );

    assign o_a_stall = stall[PORT_A];
    assign o_b_stall = stall[PORT_B];

    // Byte-lane writes from both ports; arbitration guarantees they never
    // target the same word in the same cycle. The array itself is never reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < SELW; i++) begin
            if (accept[PORT_A] && i_a_we && i_a_sel[i]) begin
                mem[i_a_addr][8*i +: 8] <= i_a_data[8*i +: 8];
            end
            if (accept[PORT_B] && i_b_we && i_b_sel[i]) begin
                mem[i_b_addr][8*i +: 8] <= i_b_data[8*i +: 8];
            end
        end
    end

    // Read-first registered reads; each register holds its port's last read word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_q[PORT_A] <= '0;
            rd_q[PORT_B] <= '0;
        end else begin
            if (rd_acc[PORT_A]) begin
                rd_q[PORT_A] <= mem[i_a_addr];
            end
            if (rd_acc[PORT_B]) begin
                rd_q[PORT_B] <= mem[i_b_addr];
            end
        end
    end

endmodule
